// File: rtl/loader_pkg.sv
// Shared types and constants for the external data-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4,
    RUN     = 3'd5,
    FAIL    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_BYTES_LOG2 = 2;

  // Byte address of word idx of a load; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [10:0] idx);
    return base + (32'(idx) << WORD_BYTES_LOG2);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: byte index counter plus 32-bit word register.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_full
);

  logic [WORD_BYTES_LOG2-1:0] idx_q, idx_d;
  logic [31:0]                buf_q, buf_d;
  logic [31:0]                merged;

  // Merge the incoming byte into its lane and advance the byte index.
  always_comb begin
    merged = buf_q;
    merged[{idx_q, 3'b000} +: 8] = byte_in;
    idx_d = idx_q;
    buf_d = buf_q;
    if (clear) begin
      idx_d = '0;
      buf_d = 32'h0000_0000;
    end else if (accept) begin
      idx_d = idx_q + 2'd1;
      buf_d = merged;
    end else begin
      idx_d = idx_q;
      buf_d = buf_q;
    end
  end

  // Index and assembly register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      buf_q <= 32'h0000_0000;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  // word already includes the byte being accepted, so the caller can latch it on word_full.
  assign word      = merged;
  assign word_full = accept && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ext_mem_loader.sv
// Boot-time loader driving the CPU external data-memory write port while holding the CPU in reset.
// Optional trailing checksum word: define LOADER_CHECKSUM_EN.
module ext_mem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        busy,
  output logic        done,
  output logic [10:0] word_count,
  output logic        error
);

  localparam logic [10:0] LAST_COUNT = 11'(NUM_WORDS);

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] adr_q, adr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [10:0] count_q, count_d;
  logic [10:0] count_next;
  logic        accept;
  logic        pack_clear;
  logic [31:0] pack_word;
  logic        pack_full;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        error_q, error_d;
`endif

  assign accept     = in_valid && in_ready_q;
  assign count_next = count_q + 11'd1;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .byte_in   (in_data),
    .clear     (pack_clear),
    .word      (pack_word),
    .word_full (pack_full)
  );

  // Next-state and next-output computation; every output is derived from the next state.
  always_comb begin
    state_d     = state_q;
    mem_write_d = 1'b0;
    wdata_d     = wdata_q;
    adr_d       = adr_q;
    count_d     = count_q;
    pack_clear  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    error_d     = error_q;
`endif
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d    = COLLECT;
          count_d    = 11'd0;
          pack_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = 32'h0000_0000;
`endif
        end else begin
          state_d = state_q;
        end
      end
      COLLECT: begin
        if (pack_full) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          wdata_d     = pack_word;
          adr_d       = word_addr(BASE_ADDR, count_q);
        end else begin
          state_d = COLLECT;
        end
      end
      WRITE: begin
        count_d = count_next;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
`endif
        if (count_next == LAST_COUNT) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (pack_full) begin
          if (pack_word == sum_q) begin
            state_d = DONE;
          end else begin
            state_d = FAIL;
            error_d = 1'b1;
          end
        end else begin
          state_d = CHECK;
        end
      end
      FAIL: begin
        if (start) begin
          state_d    = COLLECT;
          count_d    = 11'd0;
          pack_clear = 1'b1;
          sum_d      = 32'h0000_0000;
          error_d    = 1'b0;
        end else begin
          state_d = FAIL;
        end
      end
`endif
      DONE:    state_d = RUN;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == COLLECT) || (state_d == CHECK);
    busy_d      = in_ready_d || (state_d == WRITE);
    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      mem_write_q <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      adr_q       <= BASE_ADDR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 11'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 32'h0000_0000;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      mem_write_q <= mem_write_d;
      wdata_q     <= wdata_d;
      adr_q       <= adr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      error_q     <= error_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign cpu_reset     = cpu_reset_q;
  assign Ext_MemWrite  = mem_write_q;
  assign Ext_WriteData = wdata_q;
  assign Ext_DataAdr   = adr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign word_count    = count_q;
`ifdef LOADER_CHECKSUM_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_loader.sv
// Randomized bench for ext_mem_loader: three instances (1, 3 and 2 words) checked against a load-level model.
module tb_ext_mem_loader;

  logic        clk = 1'b0;
  logic        reset_s    [3];
  logic        start_s    [3];
  logic        in_valid_s [3];
  logic [7:0]  in_data_s  [3];
  logic        rdy_s      [3];
  logic        cpur_s     [3];
  logic        we_s       [3];
  logic [31:0] wd_s       [3];
  logic [31:0] adr_s      [3];
  logic        busy_s     [3];
  logic        done_s     [3];
  logic [10:0] wc_s       [3];
  logic        err_s      [3];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes [3];
  logic [31:0] mem      [3][16];
  logic [31:0] lw       [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ext_mem_loader #(
      .BASE_ADDR ((g == 0) ? 32'h0000_0000 : (g == 1) ? 32'h0000_0100 : 32'h0000_0040),
      .NUM_WORDS ((g == 0) ? 1 : (g == 1) ? 3 : 2)
    ) dut (
      .clk           (clk),
      .reset         (reset_s[g]),
      .start         (start_s[g]),
      .in_valid      (in_valid_s[g]),
      .in_data       (in_data_s[g]),
      .in_ready      (rdy_s[g]),
      .cpu_reset     (cpur_s[g]),
      .Ext_MemWrite  (we_s[g]),
      .Ext_WriteData (wd_s[g]),
      .Ext_DataAdr   (adr_s[g]),
      .busy          (busy_s[g]),
      .done          (done_s[g]),
      .word_count    (wc_s[g]),
      .error         (err_s[g])
    );
  end

  function automatic logic [31:0] tb_base(input int d);
    case (d)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0100;
      default: return 32'h0000_0040;
    endcase
  endfunction

  function automatic int tb_nw(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model fed by observed stores; every store must happen with the CPU held in reset.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (we_s[d] === 1'b1) begin
        logic [31:0] off;
        off = (adr_s[d] - tb_base(d)) >> 2;
        n_writes[d]++;
        mem[d][off[3:0]] = wd_s[d];
        check("store_cpu_reset", {31'd0, cpur_s[d]}, 32'd1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the byte is taken.
  task automatic send_byte(input int d, input logic [7:0] b, input int gap_max);
    int  gaps;
    int  waited;
    bit  taken;
    gaps = $urandom_range(gap_max, 0);
    repeat (gaps) begin
      in_valid_s[d] = 1'b0;
      in_data_s[d]  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid_s[d] = 1'b1;
    in_data_s[d]  = b;
    taken  = 1'b0;
    waited = 0;
    while (!taken && waited < 20) begin
      @(negedge clk);
      taken = (rdy_s[d] === 1'b1);
      @(posedge clk); #1;
      waited++;
    end
    if (!taken) check("accept_timeout", 32'd0, 32'd1);
    in_valid_s[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk); #1;
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  // One full load of tb_nw(d) words from lw[]; optional extra start after byte mid_start of word 0.
  task automatic run_load(input int d, input bit bad_sum, input int mid_start, input int gap_max);
    int          n;
    int          w0;
    logic [31:0] base;
    logic [31:0] sum;
    n    = tb_nw(d);
    base = tb_base(d);
    w0   = n_writes[d];
    sum  = 32'h0000_0000;
    pulse_start(d);
    @(negedge clk);
    check("start_cpu_reset", {31'd0, cpur_s[d]}, 32'd1);
    check("start_busy", {31'd0, busy_s[d]}, 32'd1);
    check("start_ready", {31'd0, rdy_s[d]}, 32'd1);
    check("start_wc", {21'd0, wc_s[d]}, 32'd0);
    check("start_err", {31'd0, err_s[d]}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      sum = sum + lw[i];
      for (int k = 0; k < 4; k++) begin
        if (i == 0 && k == mid_start) begin
          start_s[d] = 1'b1;
          @(posedge clk); #1;
          start_s[d] = 1'b0;
          @(negedge clk);
          check("mid_start_wc", {21'd0, wc_s[d]}, 32'd0);
          check("mid_start_busy", {31'd0, busy_s[d]}, 32'd1);
          check("mid_start_ready", {31'd0, rdy_s[d]}, 32'd1);
          @(posedge clk); #1;
        end
        send_byte(d, lw[i][8*k +: 8], gap_max);
      end
      @(negedge clk);
      check("store_we", {31'd0, we_s[d]}, 32'd1);
      check("store_addr", adr_s[d], base + 32'(4 * i));
      check("store_data", wd_s[d], lw[i]);
      check("store_ready", {31'd0, rdy_s[d]}, 32'd0);
      check("store_wc", {21'd0, wc_s[d]}, 32'(i));
      @(posedge clk); #1;
    end
`ifdef LOADER_CHECKSUM_EN
    if (bad_sum) sum = sum + 32'd1;
    for (int k = 0; k < 4; k++) send_byte(d, sum[8*k +: 8], gap_max);
`endif
    @(negedge clk);
    check("load_store_count", 32'(n_writes[d] - w0), 32'(n));
    check("end_wc", {21'd0, wc_s[d]}, 32'(n));
    check("end_cpu_reset", {31'd0, cpur_s[d]}, 32'd1);
    check("end_busy", {31'd0, busy_s[d]}, 32'd0);
    if (bad_sum) begin
      check("fail_err", {31'd0, err_s[d]}, 32'd1);
      check("fail_done", {31'd0, done_s[d]}, 32'd0);
      check("fail_ready", {31'd0, rdy_s[d]}, 32'd0);
    end else begin
      check("done_pulse", {31'd0, done_s[d]}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_low", {31'd0, done_s[d]}, 32'd0);
      check("run_cpu_reset", {31'd0, cpur_s[d]}, 32'd0);
      check("run_ready", {31'd0, rdy_s[d]}, 32'd0);
      check("run_err", {31'd0, err_s[d]}, 32'd0);
      for (int i = 0; i < n; i++) check("mem_readback", mem[d][i], lw[i]);
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) lw[i] = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset_s[d] = 1'b1; start_s[d] = 1'b0; in_valid_s[d] = 1'b0; in_data_s[d] = 8'h00;
      n_writes[d] = 0;
      for (int i = 0; i < 16; i++) mem[d][i] = 32'h0000_0000;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) reset_s[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_cpu_reset", {31'd0, cpur_s[d]}, 32'd1);
      check("rst_ready", {31'd0, rdy_s[d]}, 32'd0);
      check("rst_we", {31'd0, we_s[d]}, 32'd0);
      check("rst_wdata", wd_s[d], 32'h0000_0000);
      check("rst_addr", adr_s[d], tb_base(d));
      check("rst_busy", {31'd0, busy_s[d]}, 32'd0);
      check("rst_done", {31'd0, done_s[d]}, 32'd0);
      check("rst_wc", {21'd0, wc_s[d]}, 32'd0);
      check("rst_err", {31'd0, err_s[d]}, 32'd0);
    end

    // Single-word load, then a reload from RUN.
    lw[0] = 32'h1234_5678;
    run_load(0, 1'b0, -1, 0);
    lw[0] = 32'hDEAD_BEEF;
    run_load(0, 1'b0, -1, 2);

    // Three words with random gaps, then a stray start in the middle of word 0.
    rand_words();
    run_load(1, 1'b0, -1, 3);
    rand_words();
    run_load(1, 1'b0, 2, 2);

    // Reset after the sixth byte aborts the load.
    pulse_start(1);
    for (int b = 0; b < 6; b++) send_byte(1, 8'(b + 8'h11), 1);
    reset_s[1] = 1'b1;
    @(posedge clk); #1;
    reset_s[1] = 1'b0;
    @(negedge clk);
    check("abort_cpu_reset", {31'd0, cpur_s[1]}, 32'd1);
    check("abort_wc", {21'd0, wc_s[1]}, 32'd0);
    check("abort_busy", {31'd0, busy_s[1]}, 32'd0);
    check("abort_ready", {31'd0, rdy_s[1]}, 32'd0);
    check("abort_addr", adr_s[1], 32'h0000_0100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_idle_busy", {31'd0, busy_s[1]}, 32'd0);
    rand_words();
    run_load(1, 1'b0, -1, 1);

`ifdef LOADER_CHECKSUM_EN
    lw[0] = 32'h0000_0001;
    lw[1] = 32'h0000_0002;
    run_load(2, 1'b0, -1, 1);
    run_load(2, 1'b1, -1, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("fail_hold_cpu_reset", {31'd0, cpur_s[2]}, 32'd1);
    check("fail_hold_err", {31'd0, err_s[2]}, 32'd1);
    check("fail_hold_busy", {31'd0, busy_s[2]}, 32'd0);
    rand_words();
    run_load(2, 1'b0, -1, 2);
`else
    for (int r = 0; r < 3; r++) begin
      rand_words();
      run_load(2, 1'b0, (r == 1) ? 1 : -1, 3);
    end
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
